// File: rtl/sync_ram_sdp_if.sv
// sync_ram_sdp_if -- port bundle for the simple dual-port RAM sync_ram_sdp.
//
// Write port : wr_en, wr_addr, wr_data, wr_be (one byte enable per data byte)
// Read port  : rd_en, rd_addr (request); rd_data, rd_valid (response)
// Parity     : err_inj, parity_err -- present only when SYNC_RAM_PARITY_EN
//              is defined.
//
// Modports: master issues requests and observes responses; slave is the RAM.
interface sync_ram_sdp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
`ifdef SYNC_RAM_PARITY_EN
  logic                    err_inj;
  logic                    parity_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, err_inj,
    input  rd_data, rd_valid, parity_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, err_inj,
    output rd_data, rd_valid, parity_err
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid
  );
`endif
endinterface

// File: rtl/sync_ram_sdp.sv
// sync_ram_sdp -- single-clock simple dual-port RAM with byte-enabled writes,
// registered read data and a configurable 1- or 2-cycle read pipeline.
//
// Parameters: DATA_WIDTH (multiple of 8), ADDR_WIDTH (depth 2**ADDR_WIDTH),
//             RD_LATENCY (1 or 2), RDW_MODE (0 = old data, 1 = merged new data
//             on a same-address read during write).
// Ports:      clk, rst_n (asynchronous, active-low; clears the read pipeline
//             only, memory contents survive reset), bus (sync_ram_sdp_if.slave).
// Optional:   define SYNC_RAM_PARITY_EN to store one even-parity bit per byte,
//             with bus.err_inj corrupting the stored parity of written bytes
//             and bus.parity_err flagging a bad byte alongside rd_valid.
module sync_ram_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input logic           clk,
  input logic           rst_n,
  sync_ram_sdp_if.slave bus
);
  localparam int NB      = DATA_WIDTH / 8;
  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam bit RDW_NEW = (RDW_MODE != 32'sd0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  wr_go_s;
  logic                  merge_s;
  logic [DATA_WIDTH-1:0] old_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0] mem_par_r [DEPTH];
  logic [NB-1:0] rd_par_s;
  logic          rd_err_s;
  logic          perr_r;

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] word);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) begin
      p[i] = ^word[8*i +: 8];
    end
    return p;
  endfunction
`endif

  // Writes are suppressed while reset is asserted.
  assign wr_go_s = bus.wr_en & rst_n;

  // Byte-masked write into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_go_s) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          mem_r[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
          mem_par_r[bus.wr_addr][i] <= (^bus.wr_data[8*i +: 8]) ^ bus.err_inj;
`endif
        end
      end
    end
  end

  // Word read this edge; in new-data mode, bytes being written to the same
  // address are forwarded from the write port.
  always_comb begin
    old_word_s = mem_r[bus.rd_addr];
    merge_s    = RDW_NEW && wr_go_s && (bus.wr_addr == bus.rd_addr);
    rd_word_s  = old_word_s;
    for (int i = 0; i < NB; i++) begin
      if (merge_s && bus.wr_be[i]) begin
        rd_word_s[8*i +: 8] = bus.wr_data[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = old_word_s[8*i +: 8];
      end
    end
  end

`ifdef SYNC_RAM_PARITY_EN
  // Parity that travels with each read byte, recomputed against its data.
  always_comb begin
    rd_par_s = mem_par_r[bus.rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (merge_s && bus.wr_be[i]) begin
        rd_par_s[i] = (^bus.wr_data[8*i +: 8]) ^ bus.err_inj;
      end else begin
        rd_par_s[i] = mem_par_r[bus.rd_addr][i];
      end
    end
    rd_err_s = |(rd_par_s ^ byte_parity(rd_word_s));
  end
`endif

  generate
    if (RD_LATENCY == 32'sd2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_data_r;
      logic                  pipe_valid_r;
`ifdef SYNC_RAM_PARITY_EN
      logic                  pipe_err_r;
`endif
      // Stage 1 captures the array read; stage 2 presents it. Reset drops
      // anything in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_data_r  <= '0;
          pipe_valid_r <= 1'b0;
          rd_data_r    <= '0;
          rd_valid_r   <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
          pipe_err_r   <= 1'b0;
          perr_r       <= 1'b0;
`endif
        end else begin
          pipe_valid_r <= bus.rd_en;
          rd_valid_r   <= pipe_valid_r;
          if (bus.rd_en) begin
            pipe_data_r <= rd_word_s;
          end
          if (pipe_valid_r) begin
            rd_data_r <= pipe_data_r;
          end
`ifdef SYNC_RAM_PARITY_EN
          pipe_err_r <= bus.rd_en & rd_err_s;
          perr_r     <= pipe_valid_r & pipe_err_r;
`endif
        end
      end
    end else begin : g_lat1
      // Single output register; rd_data holds between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r  <= '0;
          rd_valid_r <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
          perr_r     <= 1'b0;
`endif
        end else begin
          rd_valid_r <= bus.rd_en;
          if (bus.rd_en) begin
            rd_data_r <= rd_word_s;
          end
`ifdef SYNC_RAM_PARITY_EN
          perr_r <= bus.rd_en & rd_err_s;
`endif
        end
      end
    end
  endgenerate

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`ifdef SYNC_RAM_PARITY_EN
  assign bus.parity_err = perr_r;
`endif
endmodule

// File: tb/tb_sync_ram_sdp.sv
// tb_sync_ram_sdp -- drives two RAM instances with identical traffic:
// dut0 (RD_LATENCY=1, old-data RDW) and dut1 (RD_LATENCY=2, new-data RDW).
// A word/byte-level memory model predicts each read; expectations are queued
// per instance and a negedge monitor pops and compares whenever rd_valid is
// seen, and checks that rd_data holds otherwise.
module tb_sync_ram_sdp;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sync_ram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  sync_ram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  sync_ram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  sync_ram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be = '0;
  logic          pe0, pe1;

  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
  assign bus0.wr_be = wr_be;   assign bus1.wr_be = wr_be;
  assign bus0.rd_en = rd_en;   assign bus1.rd_en = rd_en;
  assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr;
`ifdef SYNC_RAM_PARITY_EN
  logic err_inj = 1'b0;
  assign bus0.err_inj = err_inj; assign bus1.err_inj = err_inj;
  assign pe0 = bus0.parity_err;  assign pe1 = bus1.parity_err;
`else
  assign pe0 = 1'b0;
  assign pe1 = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            done_cyc;
    bit            perr;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [NB-1:0] bad_m [DEPTH];
  logic [DW-1:0] last_v [2];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One clock of traffic: the model predicts the read from the contents
  // before this edge's write (dut1 sees same-address written bytes), then
  // applies the write.
  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input bit re, input int ra, input bit ei);
    @(negedge clk); #1;
    wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra[AW-1:0];
`ifdef SYNC_RAM_PARITY_EN
    err_inj = ei;
`endif
    if (re) begin
      for (int k = 0; k < 2; k++) begin
        exp_t          e;
        logic [DW-1:0] v;
        logic [NB-1:0] b;
        v = mem_m[ra];
        b = bad_m[ra];
        if (k == 1 && we && wa == ra) begin
          for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
              v[8*i +: 8] = wd[8*i +: 8];
              b[i] = ei;
            end
          end
        end
        e.data = v;
        e.perr = |b;
        e.done_cyc = cyc + k + 1;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_m[wa][8*i +: 8] = wd[8*i +: 8];
          bad_m[wa][i] = ei;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
  endtask

  // One-cycle reset pulse with requests that must be ignored.
  task automatic pulse_reset(input int junk_addr);
    @(negedge clk); #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    last_v[0] = '0;
    last_v[1] = '0;
    wr_en = 1'b1; wr_addr = junk_addr[AW-1:0]; wr_data = 32'h5A5A_5A5A; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = junk_addr[AW-1:0];
    @(negedge clk); #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic mon_one(input int id, input logic v, input logic [DW-1:0] d, input logic pe);
    exp_t e;
    int   sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut%0d unexpected_valid: got rd_valid=1 data %h, want no read (cycle %0d)", id, d, cyc);
      end else begin
        if (id == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("dut%0d rd_data", id), d, e.data);
        check($sformatf("dut%0d valid_cycle", id), cyc, e.done_cyc);
`ifdef SYNC_RAM_PARITY_EN
        check($sformatf("dut%0d parity_err", id), {31'd0, pe}, {31'd0, e.perr});
`endif
        last_v[id] = e.data;
      end
    end else begin
      check($sformatf("dut%0d rd_data_hold", id), d, last_v[id]);
`ifdef SYNC_RAM_PARITY_EN
      check($sformatf("dut%0d parity_err_idle", id), {31'd0, pe}, 32'd0);
`endif
    end
  endtask

  // Monitor: every falling edge, compare each instance's response.
  always @(negedge clk) begin
    mon_one(0, bus0.rd_valid, bus0.rd_data, pe0);
    mon_one(1, bus1.rd_valid, bus1.rd_data, pe1);
  end

  initial begin
    last_v[0] = '0;
    last_v[1] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Define every location before reading anything.
    for (int a = 0; a < DEPTH; a++) step(1'b1, a, $urandom, 4'hF, 1'b0, 0, 1'b0);

    // Full-word write then read.
    step(1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 5, 1'b0);
    idle(); idle();

    // Partial byte write.
    step(1'b1, 3, 32'h1122_3344, 4'hF, 1'b0, 0, 1'b0);
    step(1'b1, 3, 32'hAABB_CCDD, 4'b0101, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 3, 1'b0);

    // Same-address read during write, then a follow-up read.
    step(1'b1, 7, 32'h0000_0000, 4'hF, 1'b0, 0, 1'b0);
    step(1'b1, 7, 32'hCAFE_F00D, 4'hF, 1'b1, 7, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 7, 1'b0);

    // Zero byte enables leave the word untouched.
    step(1'b1, 9, 32'hFFFF_FFFF, 4'h0, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 9, 1'b0);
    idle(); idle();

    // Back-to-back reads of 0..7.
    for (int a = 0; a < 8; a++) step(1'b1, a, a, 4'hF, 1'b0, 0, 1'b0);
    for (int a = 0; a < 8; a++) step(1'b0, 0, '0, '0, 1'b1, a, 1'b0);
    idle(); idle();

    // Reset the cycle after a read: dut1's read is lost, memory survives.
    step(1'b1, 20, 32'h1357_9BDF, 4'hF, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 20, 1'b0);
    pulse_reset(20);
    idle(); idle();
    step(1'b0, 0, '0, '0, 1'b1, 20, 1'b0);
    idle(); idle();

`ifdef SYNC_RAM_PARITY_EN
    step(1'b1, 12, 32'h0F0F_0F0F, 4'hF, 1'b0, 0, 1'b1);
    step(1'b0, 0, '0, '0, 1'b1, 12, 1'b0);
    step(1'b1, 12, 32'h0F0F_0F0F, 4'hF, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, '0, 1'b1, 12, 1'b0);
    idle(); idle();
`endif

    // Random traffic over a small address window to force collisions.
    repeat (400) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    repeat (4) idle();
    check("drain dut0 pending", q0.size(), 32'd0);
    check("drain dut1 pending", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_ram_sdp.md
SYNC_RAM_SDP -- requirements
Module: sync_ram_sdp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits; must be a multiple of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: address width; depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency in clocks; legal values 1 or 2.
REQ-004 SHALL have parameter RDW_MODE, default 0: same-address read-during-write policy; 0 = old data, 1 = new (merged) data.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port wr_en, input, 1: write request.
REQ-008 SHALL have port wr_addr, input, ADDR_WIDTH: write address.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH: write data.
REQ-010 SHALL have port wr_be, input, DATA_WIDTH/8: byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 SHALL have port rd_en, input, 1: read request.
REQ-012 SHALL have port rd_addr, input, ADDR_WIDTH: read address.
REQ-013 SHALL have port rd_data, output, DATA_WIDTH: registered read data.
REQ-014 SHALL have port rd_valid, output, 1: one-cycle qualifier for rd_data.

Function
REQ-015 SHALL write, on a rising edge with wr_en=1, each byte of mem[wr_addr] whose wr_be bit is 1; bytes with wr_be bit 0 are unchanged.
REQ-016 SHALL treat wr_en=1 with wr_be=0 as a no-op.
REQ-017 SHALL, for rd_en sampled high at edge N, drive rd_data=mem[rd_addr] with rd_valid=1 after edge N+RD_LATENCY-1, i.e. RD_LATENCY=1 at edge N, RD_LATENCY=2 at edge N+1.
REQ-018 SHALL accept one read per clock, back-to-back, with no bubbles; rd_valid follows rd_en delayed by RD_LATENCY edges.
REQ-019 SHALL hold rd_data at its last value and drive rd_valid=0 on cycles with no completing read.
REQ-020 SHALL, when wr_en=1, rd_en=1 and wr_addr==rd_addr at the same edge, return pre-write contents if RDW_MODE=0; if RDW_MODE=1, return wr_data for enabled bytes and old contents for the rest.
REQ-021 SHALL perform independent reads and writes at different addresses in the same cycle with no interaction.
REQ-022 SHALL leave memory contents undefined after power-up; no initialisation.

Reset
REQ-023 SHALL, while rst_n=0, force rd_data=0, rd_valid=0 and clear the RD_LATENCY=2 pipeline stage, asynchronously.
REQ-024 SHALL drop any read in flight when rst_n asserts; no rd_valid for it after release.
REQ-025 SHALL ignore wr_en and rd_en while rst_n=0; memory contents are not reset and are preserved across reset.

Configuration
REQ-026 SHALL, with macro SYNC_RAM_PARITY_EN defined, store one even-parity bit per byte, add input err_inj (1 bit; inverts the stored parity of every written byte) and output parity_err (1 bit, reset 0), asserted together with rd_valid when any read byte's parity mismatches; with the macro undefined, no parity storage and neither port exists.

Verification
REQ-027 SHALL cover: DATA_WIDTH=32, write 0xDEADBEEF to addr 5, wr_be=4'hF, then read addr 5 -> rd_data=0xDEADBEEF, rd_valid high one cycle, at RD_LATENCY 1 and 2.
REQ-028 SHALL cover: addr 3 holds 0x11223344, write 0xAABBCCDD with wr_be=4'b0101 -> read returns 0x11BB33DD.
REQ-029 SHALL cover: addr 7 holds 0x00000000, same-edge write 0xCAFEF00D (wr_be=4'hF) and read addr 7 -> 0x00000000 with RDW_MODE=0; 0xCAFEF00D with RDW_MODE=1; next read -> 0xCAFEF00D in both modes.
REQ-030 SHALL cover: rd_en high 8 consecutive cycles, addrs 0..7 preloaded with 0..7 -> 8 consecutive rd_valid pulses, data 0..7 in order, no gaps.
REQ-031 SHALL cover: RD_LATENCY=2, rst_n pulsed low one cycle after rd_en -> rd_data=0, no rd_valid for that read; memory still returns the prior value on a later read.
REQ-032 SHALL cover, with SYNC_RAM_PARITY_EN: write 0x0F0F0F0F with err_inj=1, then read -> parity_err=1 with rd_valid; rewrite with err_inj=0, then read -> parity_err=0.
